direct_cache_wb: RTL and testbench
==================================

Name: direct_cache_wb

Overview:
Parametrised direct-mapped, write-back, write-allocate cache between the CPU load/store port and main memory. It generalises the current single-configuration cache in several ways: configurable line count, words per line and address width. It adds a proper valid/ready memory handshake with variable latency, correct dirty-victim writeback before refill, synchronous reset, and hit/miss counters. All addresses are word addresses.

Parameters:
ADDR_W, 32, word-address width.
DATA_W, 32, data word width.
LINES, 1024, number of cache lines (power of 2, >=2).
WORDS, 4, words per line (power of 2, >=2).
CNT_W, 32, width of the hit and miss counters.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
cpu_req  in  1  request valid; held with addr/we/wdata until cpu_ready.
cpu_we  in  1  1 = store, 0 = load.
cpu_addr  in  ADDR_W  word address.
cpu_wdata  in  DATA_W  store data.
cpu_rdata  out  DATA_W  load data; valid while cpu_ready=1.
cpu_ready  out  1  one-cycle completion pulse.
mem_req  out  1  memory beat request.
mem_we  out  1  1 = write beat.
mem_addr  out  ADDR_W  beat word address.
mem_wdata  out  DATA_W  write beat data.
mem_rdata  in  DATA_W  read data; valid in the mem_ack cycle.
mem_ack  in  1  beat complete.
hit_cnt  out  CNT_W  requests served as a hit; wraps.
miss_cnt  out  CNT_W  requests that missed; wraps.

Behaviour:
- Address split: offset = addr[OW-1:0] with OW = log2(WORDS); index = next log2(LINES) bits; tag = remaining upper bits.
- Reset (synchronous):
  - All valid and dirty bits are cleared; data and tag arrays are not cleared.
  - State goes to IDLE; beat counter = 0.
  - cpu_ready = 0, cpu_rdata = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, hit_cnt = 0, miss_cnt = 0.
- Reset mid-operation: the transaction is abandoned and mem_req falls in the next cycle. Dirty data is discarded and no cpu_ready is issued.
- Hit: the line is valid and its tag matches.
- State machine (registered):
  - IDLE: with cpu_req=1, evaluate the lookup.
    - Hit: a load registers the array word into cpu_rdata; a store writes cpu_wdata and sets dirty. hit_cnt+1. Go to RESP.
    - Miss with valid and dirty: miss_cnt+1; go to WB.
    - Miss otherwise: miss_cnt+1; go to FILL.
  - WB: WORDS write beats to {old_tag, index, k}, k = 0..WORDS-1 ascending, mem_wdata = stored word k. When the last beat is acked, clear dirty and go to FILL.
  - FILL: WORDS read beats to {tag, index, k}; word k is written on its ack. When the last beat is acked, set the tag, valid=1, dirty=0, and go to IDLE. The request is still held, so it now hits; hit_cnt is not incremented for this re-lookup.
  - RESP: cpu_ready=1 for exactly one cycle, then IDLE. cpu_req is ignored in RESP.
- Hit latency: request presented in IDLE at cycle N gives cpu_ready at N+1. Maximum throughput is one request per 2 cycles.
- Miss latency: the sum of all beat latencies plus 2 cycles.
- Memory handshake:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable until mem_ack.
  - The next beat may be presented in the cycle after the ack, with mem_req held high.
  - mem_ack while mem_req=0 is ignored.
  - An unbounded number of stall cycles is legal.
- Write-allocate: a store miss refills the line first, then performs the store; the store itself never writes to memory.
- Counter wrap: an increment from all-ones yields 0.
- The cpu side has no dependence on mem_ack outside WB and FILL.

Test Plan:
Common setup: LINES=4, WORDS=4, memory model rdata = addr + 0x1000, ack 1 cycle after req, unless a scenario states otherwise.
1. Cold load 0x12 -> 4 read beats at 0x10..0x13; cpu_rdata = 0x1012; miss_cnt=1. Reload 0x12 -> ready at N+1 with no mem_req; hit_cnt=1.
2. Store 0x11 = 0xDEADBEEF (hit), then load 0x11 -> 0xDEADBEEF with no memory traffic; line dirty.
3. Load 0x22 (same index, new tag) -> write beats to 0x10..0x13 with data 0x1010, 0xDEADBEEF, 0x1012, 0x1013; then read beats 0x20..0x23; cpu_rdata = 0x1022; miss_cnt=2.
4. Store miss 0x35 = 0x12345678 on a clean/invalid line -> no write beats; refill 0x34..0x37; then load 0x35 -> 0x12345678, load 0x36 -> 0x1036.
5. mem_ack delayed 5 cycles per beat -> mem_addr and mem_req stable throughout; cpu_ready only after the 4th ack plus 2 cycles.
6. rst asserted during the 2nd FILL beat -> mem_req low next cycle, counters 0, no cpu_ready. Load 0x12 afterwards -> full refill, i.e. a miss.

Source files
------------

// File: rtl/direct_cache_wb.sv
// Direct-mapped write-back, write-allocate cache between a CPU load/store port
// and a valid/ack word-beat memory interface, with hit/miss counters.
module direct_cache_wb #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LINES  = 1024,
  parameter int unsigned WORDS  = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);
  localparam int unsigned OW = $clog2(WORDS);
  localparam int unsigned IW = $clog2(LINES);
  localparam int unsigned TW = ADDR_W - OW - IW;

  typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL, S_RESP} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_data [LINES*WORDS];
  logic [TW-1:0]     r_tag  [LINES];
  logic [LINES-1:0]  r_valid;
  logic [LINES-1:0]  r_dirty;
  logic [ADDR_W-1:0] r_addr;
  logic [OW-1:0]     r_beat;
  logic              r_refill;

  logic [OW-1:0] w_off;
  logic [IW-1:0] w_idx;
  logic [TW-1:0] w_tag;
  logic          w_hit;
  logic [IW-1:0] w_ridx;
  logic [TW-1:0] w_rtag;
  logic [OW-1:0] w_next_beat;
  logic          w_last;
  logic          w_beat_done;

  assign w_off       = cpu_addr[OW-1:0];
  assign w_idx       = cpu_addr[OW +: IW];
  assign w_tag       = cpu_addr[ADDR_W-1 -: TW];
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  // Line fields of the missing request, latched so beats do not depend on cpu_addr
  assign w_ridx      = r_addr[OW +: IW];
  assign w_rtag      = r_addr[ADDR_W-1 -: TW];
  assign w_next_beat = r_beat + OW'(1);
  assign w_last      = (r_beat == OW'(WORDS - 1));
  assign w_beat_done = mem_req && mem_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_valid   <= '0;
      r_dirty   <= '0;
      r_addr    <= '0;
      r_beat    <= '0;
      r_refill  <= 1'b0;
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      cpu_ready <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (cpu_req) begin
            if (w_hit) begin
              if (cpu_we) begin
                r_data[{w_idx, w_off}] <= cpu_wdata;
                r_dirty[w_idx]         <= 1'b1;
              end else begin
                cpu_rdata <= r_data[{w_idx, w_off}];
              end
              // The post-refill re-lookup was already counted as a miss
              if (!r_refill) hit_cnt <= hit_cnt + CNT_W'(1);
              r_refill  <= 1'b0;
              cpu_ready <= 1'b1;
              r_state   <= S_RESP;
            end else begin
              miss_cnt <= miss_cnt + CNT_W'(1);
              r_addr   <= cpu_addr;
              r_beat   <= '0;
              mem_req  <= 1'b1;
              if (r_valid[w_idx] && r_dirty[w_idx]) begin
                mem_we    <= 1'b1;
                mem_addr  <= {r_tag[w_idx], w_idx, OW'(0)};
                mem_wdata <= r_data[{w_idx, OW'(0)}];
                r_state   <= S_WB;
              end else begin
                mem_we   <= 1'b0;
                mem_addr <= {w_tag, w_idx, OW'(0)};
                r_state  <= S_FILL;
              end
            end
          end
        end
        S_WB: begin
          if (w_beat_done) begin
            if (w_last) begin
              r_dirty[w_ridx] <= 1'b0;
              r_beat          <= '0;
              mem_we          <= 1'b0;
              mem_addr        <= {w_rtag, w_ridx, OW'(0)};
              r_state         <= S_FILL;
            end else begin
              r_beat    <= w_next_beat;
              mem_addr  <= {r_tag[w_ridx], w_ridx, w_next_beat};
              mem_wdata <= r_data[{w_ridx, w_next_beat}];
            end
          end
        end
        S_FILL: begin
          if (w_beat_done) begin
            r_data[{w_ridx, r_beat}] <= mem_rdata;
            if (w_last) begin
              r_tag[w_ridx]   <= w_rtag;
              r_valid[w_ridx] <= 1'b1;
              r_dirty[w_ridx] <= 1'b0;
              r_refill        <= 1'b1;
              mem_req         <= 1'b0;
              r_state         <= S_IDLE;
            end else begin
              r_beat   <= w_next_beat;
              mem_addr <= {w_rtag, w_ridx, w_next_beat};
            end
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_direct_cache_wb.sv
// Scoreboard bench for direct_cache_wb: expected memory beats and load data are
// queued when a request is issued and retired as the DUT produces them.
module tb_direct_cache_wb;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_ready;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [CW-1:0] hit_cnt, miss_cnt;

  direct_cache_wb #(.ADDR_W(AW), .DATA_W(DW), .LINES(4), .WORDS(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } beat_t;

  beat_t         exp_beats[$];
  logic [DW-1:0] exp_rd[$];
  int            n_chk = 0;
  int            n_pass = 0;
  int            cyc = 0;
  int            lat = 1;
  int            cnt = 0;
  int            beats_done = 0;
  int            last_ack_cyc = 0;
  bit            spur = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic push_fill(input logic [AW-1:0] base);
    for (int k = 0; k < 4; k++) begin
      beat_t b;
      b.we = 1'b0; b.addr = base + AW'(k); b.wdata = '0;
      exp_beats.push_back(b);
    end
  endtask

  task automatic push_wb(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    beat_t b;
    b.we = 1'b1; b.addr = addr; b.wdata = data;
    exp_beats.push_back(b);
  endtask

  // Memory responder: acks each beat after lat waiting cycles, rdata = addr + 0x1000
  initial begin
    logic [AW-1:0] l_addr;
    logic          l_we;
    logic [DW-1:0] l_wdata;
    mem_ack = 1'b0; mem_rdata = '0;
    l_addr = '0; l_we = 1'b0; l_wdata = '0;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack = 1'b0;
        cnt = 0;
      end else if (spur && !mem_req) begin
        mem_ack = 1'b1;
      end
      if (!mem_req) begin
        cnt = 0;
      end else if (!mem_ack) begin
        if (cnt == 0) begin
          l_addr = mem_addr; l_we = mem_we; l_wdata = mem_wdata;
          chk("beat_expected", 32'(exp_beats.size() != 0), 32'd1);
        end else begin
          chk("mem_addr_stable", 32'(mem_addr), 32'(l_addr));
          chk("mem_we_stable", 32'(mem_we), 32'(l_we));
          if (l_we) chk("mem_wdata_stable", mem_wdata, l_wdata);
        end
        if (cnt >= lat) begin
          mem_ack      = 1'b1;
          mem_rdata    = 32'(mem_addr) + 32'h1000;
          last_ack_cyc = cyc;
          beats_done++;
          if (exp_beats.size() != 0) begin
            beat_t b;
            b = exp_beats.pop_front();
            chk("beat_addr", 32'(mem_addr), 32'(b.addr));
            chk("beat_we", 32'(mem_we), 32'(b.we));
            if (b.we) chk("beat_wdata", mem_wdata, b.wdata);
          end
        end else begin
          cnt++;
        end
      end
    end
  end

  // One CPU request; entered and left one tick after a rising edge in IDLE
  task automatic access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [DW-1:0] erd, input bit hit);
    int n;
    bit got;
    if (!we) exp_rd.push_back(erd);
    cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 400) begin
      @(posedge clk); #1;
      n++;
      if (cpu_ready) got = 1'b1;
    end
    cpu_req = 1'b0;
    chk("ready_seen", 32'(got), 32'd1);
    if (got) begin
      if (hit) chk("hit_latency", 32'(n), 32'd1);
      else     chk("miss_latency", 32'(cyc), 32'(last_ack_cyc + 2));
      if (!we) chk("rdata", cpu_rdata, exp_rd.pop_front());
    end
    exp_rd.delete();
    chk("beats_left", 32'(exp_beats.size()), 32'd0);
    exp_beats.delete();
    @(posedge clk); #1;
    chk("ready_pulse", 32'(cpu_ready), 32'd0);
  endtask

  initial begin
    int b0;
    int n;
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(cpu_ready), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_hit", hit_cnt, 32'd0);
    chk("rst_miss", miss_cnt, 32'd0);
    rst = 1'b0;

    // Cold load miss, then reload hit
    push_fill(16'h10);
    access(1'b0, 16'h12, '0, 32'h1012, 1'b0);
    chk("s1_miss", miss_cnt, 32'd1);
    chk("s1_hit0", hit_cnt, 32'd0);
    access(1'b0, 16'h12, '0, 32'h1012, 1'b1);
    chk("s1_hit1", hit_cnt, 32'd1);

    // Store hit then load hit, with stray acks while idle
    spur = 1'b1;
    access(1'b1, 16'h11, 32'hDEADBEEF, '0, 1'b1);
    access(1'b0, 16'h11, '0, 32'hDEADBEEF, 1'b1);
    spur = 1'b0;
    chk("s2_hit", hit_cnt, 32'd3);

    // Dirty victim written back before refill
    push_wb(16'h10, 32'h1010);
    push_wb(16'h11, 32'hDEADBEEF);
    push_wb(16'h12, 32'h1012);
    push_wb(16'h13, 32'h1013);
    push_fill(16'h20);
    access(1'b0, 16'h22, '0, 32'h1022, 1'b0);
    chk("s3_miss", miss_cnt, 32'd2);

    // Store miss allocates without writing memory
    push_fill(16'h34);
    access(1'b1, 16'h35, 32'h12345678, '0, 1'b0);
    access(1'b0, 16'h35, '0, 32'h12345678, 1'b1);
    access(1'b0, 16'h36, '0, 32'h1036, 1'b1);
    chk("s4_miss", miss_cnt, 32'd3);
    chk("s4_hit", hit_cnt, 32'd5);

    // Slow memory
    lat = 5;
    push_fill(16'h48);
    access(1'b0, 16'h4A, '0, 32'h104A, 1'b0);
    chk("s5_miss", miss_cnt, 32'd4);

    // Reset during the second fill beat
    push_fill(16'h10);
    b0 = beats_done;
    cpu_we = 1'b0; cpu_addr = 16'h12; cpu_req = 1'b1;
    n = 0;
    while (!(beats_done == b0 + 1 && cnt == 2) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("s6_window", 32'(beats_done - b0), 32'd1);
    rst = 1'b1; cpu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_beats.delete();
    chk("s6_mem_req", 32'(mem_req), 32'd0);
    chk("s6_hit", hit_cnt, 32'd0);
    chk("s6_miss", miss_cnt, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("s6_no_ready", 32'(cpu_ready), 32'd0);
      @(posedge clk); #1;
    end
    lat = 1;
    push_fill(16'h10);
    access(1'b0, 16'h12, '0, 32'h1012, 1'b0);
    chk("s6_miss_after", miss_cnt, 32'd1);
    chk("s6_hit_after", hit_cnt, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
